// File: rtl/ram_port_arbiter_if.sv
// Bundle of the two requester ports, the shared RAM port and init status
// seen by ram_port_arbiter.
interface ram_port_arbiter_if #(
    parameter int unsigned ADDR_W = 9,
    parameter int unsigned DATA_W = 32
);
    localparam int unsigned MASK_W = DATA_W / 8;

    logic              init_done;

    logic              p0_req_valid;
    logic              p0_req_ready;
    logic              p0_req_wr;
    logic [MASK_W-1:0] p0_req_mask;
    logic [ADDR_W-1:0] p0_req_addr;
    logic [DATA_W-1:0] p0_req_wdata;
    logic              p0_rsp_valid;
    logic [DATA_W-1:0] p0_rsp_rdata;

    logic              p1_req_valid;
    logic              p1_req_ready;
    logic              p1_req_wr;
    logic [MASK_W-1:0] p1_req_mask;
    logic [ADDR_W-1:0] p1_req_addr;
    logic [DATA_W-1:0] p1_req_wdata;
    logic              p1_rsp_valid;
    logic [DATA_W-1:0] p1_rsp_rdata;

    logic              ram_en;
    logic              ram_wr;
    logic [MASK_W-1:0] ram_mask;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    modport slave (
        output init_done,
        input  p0_req_valid, p0_req_wr, p0_req_mask, p0_req_addr, p0_req_wdata,
        output p0_req_ready, p0_rsp_valid, p0_rsp_rdata,
        input  p1_req_valid, p1_req_wr, p1_req_mask, p1_req_addr, p1_req_wdata,
        output p1_req_ready, p1_rsp_valid, p1_rsp_rdata,
        output ram_en, ram_wr, ram_mask, ram_addr, ram_wdata,
        input  ram_rdata
    );

    modport master (
        input  init_done,
        output p0_req_valid, p0_req_wr, p0_req_mask, p0_req_addr, p0_req_wdata,
        input  p0_req_ready, p0_rsp_valid, p0_rsp_rdata,
        output p1_req_valid, p1_req_wr, p1_req_mask, p1_req_addr, p1_req_wdata,
        input  p1_req_ready, p1_rsp_valid, p1_rsp_rdata,
        input  ram_en, ram_wr, ram_mask, ram_addr, ram_wdata,
        output ram_rdata
    );
endinterface

// File: rtl/ram_port_arbiter.sv
// Two-requester round-robin arbiter for a single-port RAM; zero-fills the RAM
// after reset, then grants one access per cycle with alternating tie-break.
module ram_port_arbiter #(
    parameter int unsigned WORDS  = 512,
    parameter int unsigned ADDR_W = 9,
    parameter int unsigned DATA_W = 32
) (
    input logic               aclk,
    input logic               aresetn,
    ram_port_arbiter_if.slave bus
);
    localparam int unsigned       MASK_W    = DATA_W / 8;
    localparam logic [ADDR_W-1:0] FILL_LAST = ADDR_W'(WORDS - 1);

    typedef enum logic [1:0] {HOLD, INIT, RUN} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] fill_cnt;
    logic              last_grant;
    logic              pend_valid;
    logic              pend_owner;
    logic              run;
    logic              grant0, grant1;

    assign run = (state == RUN);
    // On a tie the requester that did not win last time gets the port.
    assign grant0 = run && bus.p0_req_valid && (!bus.p1_req_valid || last_grant);
    assign grant1 = run && bus.p1_req_valid && (!bus.p0_req_valid || !last_grant);

    assign bus.p0_req_ready = grant0;
    assign bus.p1_req_ready = grant1;
    assign bus.init_done    = run;

    assign bus.p0_rsp_valid = pend_valid && !pend_owner;
    assign bus.p1_rsp_valid = pend_valid &&  pend_owner;
    assign bus.p0_rsp_rdata = bus.p0_rsp_valid ? bus.ram_rdata : '0;
    assign bus.p1_rsp_rdata = bus.p1_rsp_valid ? bus.ram_rdata : '0;

    always_comb begin
        state_nxt     = state;
        bus.ram_en    = 1'b0;
        bus.ram_wr    = 1'b0;
        bus.ram_mask  = '0;
        bus.ram_addr  = '0;
        bus.ram_wdata = '0;
        case (state)
            HOLD: state_nxt = INIT;
            INIT: begin
                bus.ram_en   = 1'b1;
                bus.ram_wr   = 1'b1;
                bus.ram_mask = '1;
                bus.ram_addr = fill_cnt;
                if (fill_cnt == FILL_LAST) state_nxt = RUN;
            end
            RUN: begin
                if (grant0) begin
                    bus.ram_en    = 1'b1;
                    bus.ram_wr    = bus.p0_req_wr;
                    bus.ram_mask  = bus.p0_req_wr ? bus.p0_req_mask : '0;
                    bus.ram_addr  = bus.p0_req_addr;
                    bus.ram_wdata = bus.p0_req_wdata;
                end else if (grant1) begin
                    bus.ram_en    = 1'b1;
                    bus.ram_wr    = bus.p1_req_wr;
                    bus.ram_mask  = bus.p1_req_wr ? bus.p1_req_mask : '0;
                    bus.ram_addr  = bus.p1_req_addr;
                    bus.ram_wdata = bus.p1_req_wdata;
                end
            end
            default: state_nxt = HOLD;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state      <= HOLD;
            fill_cnt   <= '0;
            last_grant <= 1'b1;
            pend_valid <= 1'b0;
            pend_owner <= 1'b0;
        end else begin
            state <= state_nxt;
            // Counter parks on the last address instead of wrapping.
            if (state == INIT && fill_cnt != FILL_LAST) fill_cnt <= fill_cnt + 1'b1;
            if (grant0)      last_grant <= 1'b0;
            else if (grant1) last_grant <= 1'b1;
            pend_valid <= (grant0 && !bus.p0_req_wr) || (grant1 && !bus.p1_req_wr);
            pend_owner <= grant1;
        end
    end
endmodule

// File: tb/tb_ram_port_arbiter.sv
// Scoreboard bench for ram_port_arbiter: random two-port traffic against a
// word-array reference model, with a behavioural RAM behind the arbiter.
module tb_ram_port_arbiter;
    localparam int unsigned WORDS  = 512;
    localparam int unsigned ADDR_W = 9;
    localparam int unsigned DATA_W = 32;

    typedef struct packed {
        logic        v;
        logic        wr;
        logic [3:0]  m;
        logic [8:0]  a;
        logic [31:0] d;
    } req_t;

    typedef struct {
        logic        owner;
        logic [31:0] data;
        int unsigned due;
    } rsp_t;

    logic aclk = 1'b0;
    logic aresetn = 1'b0;
    int unsigned cyc = 0;
    int checks = 0;
    int errors = 0;

    logic [31:0] ram_mem [WORDS];
    logic [31:0] ref_mem [WORDS];
    logic        model_last;
    rsp_t        exp_q [$];
    rsp_t        mon_e;

    ram_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    ram_port_arbiter #(.WORDS(WORDS), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .aclk    (aclk),
        .aresetn (aresetn),
        .bus     (bus)
    );

    always #5 aclk = ~aclk;
    always @(posedge aclk) cyc <= cyc + 1;

    // Behavioural single-port RAM with one-cycle read latency.
    always @(posedge aclk) begin
        if (bus.ram_en) begin
            if (bus.ram_wr) begin
                for (int b = 0; b < 4; b++)
                    if (bus.ram_mask[b]) ram_mem[bus.ram_addr][b*8 +: 8] <= bus.ram_wdata[b*8 +: 8];
            end else begin
                bus.ram_rdata <= ram_mem[bus.ram_addr];
            end
        end
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [127:0] all_outs();
        return {bus.init_done, bus.p0_req_ready, bus.p1_req_ready, bus.p0_rsp_valid,
                bus.p1_rsp_valid, bus.p0_rsp_rdata, bus.p1_rsp_rdata,
                bus.ram_en, bus.ram_wr, bus.ram_mask, bus.ram_addr} | 128'(bus.ram_wdata);
    endfunction

    task automatic drive(input req_t r0, input req_t r1);
        bus.p0_req_valid = r0.v; bus.p0_req_wr = r0.wr; bus.p0_req_mask = r0.m;
        bus.p0_req_addr  = r0.a; bus.p0_req_wdata = r0.d;
        bus.p1_req_valid = r1.v; bus.p1_req_wr = r1.wr; bus.p1_req_mask = r1.m;
        bus.p1_req_addr  = r1.a; bus.p1_req_wdata = r1.d;
    endtask

    function automatic req_t rand_req(input int unsigned pct_valid, input int unsigned max_addr);
        req_t r;
        r.v  = ($urandom_range(99, 0) < pct_valid);
        r.wr = $urandom_range(1, 0) == 1;
        r.m  = 4'($urandom);
        r.a  = 9'($urandom_range(max_addr, 0));
        r.d  = $urandom;
        return r;
    endfunction

    // One RUN cycle: drive, predict grant and RAM port, update reference memory.
    task automatic step(input req_t r0, input req_t r1);
        logic g0, g1;
        req_t g;
        logic [47:0] exp_ram;
        rsp_t e;
        @(negedge aclk);
        drive(r0, r1);
        #1;
        g0 = r0.v && (!r1.v || model_last);
        g1 = r1.v && !g0;
        check("ready", 128'({bus.p0_req_ready, bus.p1_req_ready}), 128'({g0, g1}));
        g = g0 ? r0 : (g1 ? r1 : '0);
        exp_ram = g.v ? {1'b1, g.wr, (g.wr ? g.m : 4'h0), g.a, g.d} : '0;
        check("ram_port", 128'({bus.ram_en, bus.ram_wr, bus.ram_mask, bus.ram_addr, bus.ram_wdata}),
              128'(exp_ram));
        if (g.v) begin
            model_last = g1;
            if (g.wr) begin
                for (int b = 0; b < 4; b++)
                    if (g.m[b]) ref_mem[g.a][b*8 +: 8] = g.d[b*8 +: 8];
            end else begin
                e.owner = g1;
                e.data  = ref_mem[g.a];
                e.due   = cyc + 1;
                exp_q.push_back(e);
            end
        end
    endtask

    // Called right after reset release at a falling edge: the current cycle is HOLD.
    task automatic init_check();
        logic [127:0] exp;
        #1;
        check("hold_outputs", all_outs(), '0);
        for (int unsigned i = 0; i < WORDS; i++) begin
            @(negedge aclk);
            drive(rand_req(70, 511), rand_req(70, 511));
            #1;
            exp = 128'({1'b1, 1'b1, 4'hF, 9'(i), 32'h0, 3'b000});
            check("init_write", 128'({bus.ram_en, bus.ram_wr, bus.ram_mask, bus.ram_addr,
                  bus.ram_wdata, bus.p0_req_ready, bus.p1_req_ready, bus.init_done}), exp);
        end
        @(negedge aclk);
        drive('0, '0);
        #1;
        check("init_done", 128'(bus.init_done), 128'(1));
        for (int i = 0; i < WORDS; i++) ref_mem[i] = '0;
        model_last = 1'b1;
    endtask

    always @(negedge aclk) begin
        if (aresetn) begin
            if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
                mon_e = exp_q.pop_front();
                check("rsp", 128'({bus.p0_rsp_valid, bus.p1_rsp_valid,
                      (mon_e.owner ? bus.p1_rsp_rdata : bus.p0_rsp_rdata)}),
                      128'({!mon_e.owner, mon_e.owner, mon_e.data}));
            end else if (bus.p0_rsp_valid || bus.p1_rsp_valid) begin
                check("rsp_unexpected", 128'({bus.p0_rsp_valid, bus.p1_rsp_valid}), '0);
            end
        end
    end

    initial begin
        req_t r0, r1;
        drive('0, '0);
        bus.ram_rdata = '0;
        model_last = 1'b1;
        #23;
        check("reset_outputs", all_outs(), '0);
        @(negedge aclk);
        aresetn = 1'b1;
        init_check();

        // Both ports reading for 6 cycles: alternating grants starting with p0.
        for (int i = 0; i < 6; i++) begin
            r0 = '{v: 1'b1, wr: 1'b0, m: 4'hF, a: 9'(i), d: 32'h0};
            r1 = '{v: 1'b1, wr: 1'b0, m: 4'hF, a: 9'(i + 20), d: 32'h0};
            step(r0, r1);
        end
        step('0, '0);

        // p0 read of address 5 returns zero after fill.
        step('{v: 1'b1, wr: 1'b0, m: 4'h0, a: 9'd5, d: 32'h0}, '0);
        step('0, '0);

        // Partial-mask write followed immediately by a read of the same word.
        step('0, '{v: 1'b1, wr: 1'b1, m: 4'b0011, a: 9'd7, d: 32'hDEADBEEF});
        step('{v: 1'b1, wr: 1'b0, m: 4'h0, a: 9'd7, d: 32'h0}, '0);
        // Mask-0 write still occupies the port.
        step('{v: 1'b1, wr: 1'b1, m: 4'h0, a: 9'd7, d: 32'h12345678}, '0);
        step('0, '{v: 1'b1, wr: 1'b0, m: 4'h0, a: 9'd7, d: 32'h0});

        for (int i = 0; i < 400; i++) step(rand_req(65, 15), rand_req(65, 15));
        step('0, '0);

        // Read accepted just before reset must never respond; fill restarts at 0.
        step('0, '{v: 1'b1, wr: 1'b0, m: 4'h0, a: 9'd7, d: 32'h0});
        @(posedge aclk);
        #1;
        aresetn = 1'b0;
        exp_q.delete();
        drive('0, '0);
        @(negedge aclk);
        #1;
        check("reset_mid_run_outputs", all_outs(), '0);
        @(negedge aclk);
        aresetn = 1'b1;
        init_check();

        for (int i = 0; i < 100; i++) step(rand_req(80, 31), rand_req(80, 31));
        step('0, '0);
        step('0, '0);
        check("scoreboard_drained", 128'(exp_q.size()), '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ram_port_arbiter.md
RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

Interface
REQ-001 Parameter: WORDS, 512, RAM depth in words.
REQ-002 Parameter: ADDR_W, 9, address width; SHALL equal clog2(WORDS).
REQ-003 Parameter: DATA_W, 32, data width; byte-mask width MASK_W SHALL be DATA_W/8 (4).
REQ-004 aclk  in  1  single clock; all state SHALL change on its rising edge.
REQ-005 aresetn  in  1  asynchronous, active-low reset.
REQ-006 init_done  out  1  high once RAM zero-fill is complete.
REQ-007 pN_req_valid  in  1  request valid from requester N (N = 0, 1).
REQ-008 pN_req_ready  out  1  request accepted this cycle when valid && ready.
REQ-009 pN_req_wr  in  1  1 = write, 0 = read.
REQ-010 pN_req_mask  in  MASK_W  byte-write enables; ignored for reads.
REQ-011 pN_req_addr  in  ADDR_W  word address.
REQ-012 pN_req_wdata  in  DATA_W  write data.
REQ-013 pN_rsp_valid  out  1  one-cycle pulse: read data for N is on pN_rsp_rdata.
REQ-014 pN_rsp_rdata  out  DATA_W  read data; meaningful only while pN_rsp_valid.
REQ-015 ram_en / ram_wr  out  1 each  RAM port enable / write select.
REQ-016 ram_mask  out  MASK_W  RAM byte-write enables.
REQ-017 ram_addr / ram_wdata  out  ADDR_W / DATA_W  RAM address / write data.
REQ-018 ram_rdata  in  DATA_W  RAM read data, valid one cycle after a read enable.

Function
REQ-019 FSM states: HOLD, INIT, RUN; HOLD SHALL go to INIT on the first edge after reset release.
REQ-020 INIT: one write per cycle (ram_en=1, ram_wr=1, ram_mask all ones, ram_wdata=0) at ram_addr = fill counter 0..WORDS-1.
REQ-021 Fill counter SHALL increment per INIT cycle; the cycle writing WORDS-1 SHALL move to RUN; the counter SHALL NOT wrap.
REQ-022 init_done SHALL be 1 only in RUN; pN_req_ready SHALL be 0 in HOLD and INIT.
REQ-023 RUN: if exactly one pN_req_valid is high, that requester is granted; if both are high, the one not equal to last_grant is granted; if neither, no grant.
REQ-024 pN_req_ready = RUN && granted(N) SHALL be combinational from valids and last_grant; at most one ready per cycle.
REQ-025 On accept: ram_en=1, ram_wr=req_wr, ram_mask=(req_wr ? req_mask : 0), ram_addr and ram_wdata SHALL pass through the same cycle; last_grant SHALL be set to N.
REQ-026 No access in a cycle: ram_en, ram_wr, ram_mask, ram_addr, ram_wdata SHALL all be 0.
REQ-027 Read accepted at cycle T: pN_rsp_valid=1 at T+1 only, with pN_rsp_rdata=ram_rdata; the other port's rsp_valid SHALL be 0.
REQ-028 Writes SHALL produce no response; a write with mask 0 SHALL still consume a RAM cycle.
REQ-029 Throughput: one access per cycle with no bubbles; a read at T+1 of an address written at T SHALL return the written data.
REQ-030 Responses SHALL have no backpressure; a single pending-read register (valid + owner) SHALL suffice.

Reset
REQ-031 aresetn low SHALL asynchronously force HOLD, fill counter=0, last_grant=1 (p0 wins the first tie), and clear the pending read.
REQ-032 While in reset and in HOLD, all outputs SHALL be 0.
REQ-033 A read accepted in the cycle before reset assertion SHALL produce no response; after release, INIT SHALL restart from address 0.

Verification
REQ-034 Release reset -> 1 HOLD cycle, then 512 zero writes to addr 0..511 on consecutive cycles; init_done=1 on the following cycle.
REQ-035 After init, p0 read addr 5 -> p0_rsp_valid pulses the next cycle with rdata=0x00000000; p1_rsp_valid stays 0.
REQ-036 Both ports hold reads valid for 6 cycles -> grants p0,p1,p0,p1,p0,p1; responses alternate one cycle later.
REQ-037 p1 write addr 7 data 0xDEADBEEF mask 0b0011, then p0 read addr 7 next cycle -> p0_rsp_rdata=0x0000BEEF.
REQ-038 p1 read accepted, aresetn low the next cycle -> p1_rsp_valid never asserts; after release, INIT restarts at addr 0.
